// File: rtl/layer3_pixel_buffer.sv
// layer3_pixel_buffer: frame buffer between layer-2 convolution writes and
// layer-3 2x2 max-pool reads. Pixels land in four banks split by row/col
// parity so one read returns a whole 2x2 window in a single cycle.
module layer3_pixel_buffer #(
    parameter int unsigned IN_DIM = 32,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_enable,
    input  logic [ADDR_W-1:0] input_row,
    input  logic [ADDR_W-1:0] input_col,
    input  logic [DATA_W-1:0] input_data,
    output logic              pixel_store_done,
    input  logic              read_pixel_signal,
    input  logic [ADDR_W-1:0] read_row_addr,
    input  logic [ADDR_W-1:0] read_col_addr,
    input  logic              layer3_calculation_done,
    output logic [DATA_W-1:0] input_data_even_even,
    output logic [DATA_W-1:0] input_data_even_odd,
    output logic [DATA_W-1:0] input_data_odd_even,
    output logic [DATA_W-1:0] input_data_odd_odd,
    output logic              buffer_full
);

    localparam int unsigned HALF  = IN_DIM / 2;
    localparam int unsigned DEPTH = HALF * HALF;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(IN_DIM * IN_DIM + 1);

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(IN_DIM * IN_DIM - 1);
    localparam logic [ADDR_W-1:0] DIM_A    = ADDR_W'(IN_DIM);
    localparam logic [ADDR_W-1:0] HALF_A   = ADDR_W'(HALF);

    typedef enum logic {
        FILL  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] write_count;

    logic wr_en_c;
    logic wr_last_c;
    logic rd_en_c;
    logic rd_zero_c;

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    logic [DATA_W-1:0] mem_ee [DEPTH];
    logic [DATA_W-1:0] mem_eo [DEPTH];
    logic [DATA_W-1:0] mem_oe [DEPTH];
    logic [DATA_W-1:0] mem_oo [DEPTH];

    // Bank word index: writes use the half-resolution coordinate, reads are already pooled.
    assign wr_idx = IDX_W'(32'(input_row >> 1) * HALF + 32'(input_col >> 1));
    assign rd_idx = IDX_W'(32'(read_row_addr) * HALF + 32'(read_col_addr));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave FILL on the frame's last accepted write, leave SERVE on pool done.
    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (wr_last_c) state_next = SERVE;
            SERVE:   if (layer3_calculation_done) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Per-state strobes: writes only count in FILL, reads only act in SERVE.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_last_c = 1'b0;
        rd_en_c   = 1'b0;
        rd_zero_c = 1'b0;
        case (state)
            FILL: begin
                wr_en_c   = save_enable && (input_row < DIM_A) && (input_col < DIM_A);
                wr_last_c = wr_en_c && (write_count == LAST_CNT);
            end
            SERVE: begin
                rd_en_c   = read_pixel_signal;
                rd_zero_c = (read_row_addr >= HALF_A) || (read_col_addr >= HALF_A);
            end
            default: ;
        endcase
    end

    // Accepted-write counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_count      <= '0;
            pixel_store_done <= 1'b0;
            buffer_full      <= 1'b0;
        end else begin
            pixel_store_done <= wr_last_c;
            buffer_full      <= (state_next == SERVE);
            if (wr_last_c) begin
                write_count <= '0;
            end else if (wr_en_c) begin
                write_count <= write_count + CNT_W'(1);
            end
        end
    end

    // Bank storage, steered by row/col parity; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            case ({input_row[0], input_col[0]})
                2'b00:   mem_ee[wr_idx] <= input_data;
                2'b01:   mem_eo[wr_idx] <= input_data;
                2'b10:   mem_oe[wr_idx] <= input_data;
                default: mem_oo[wr_idx] <= input_data;
            endcase
        end
    end

    // Registered 2x2 window read; out-of-range windows read as zero, idle cycles hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            input_data_even_even <= '0;
            input_data_even_odd  <= '0;
            input_data_odd_even  <= '0;
            input_data_odd_odd   <= '0;
        end else if (rd_en_c) begin
            if (rd_zero_c) begin
                input_data_even_even <= '0;
                input_data_even_odd  <= '0;
                input_data_odd_even  <= '0;
                input_data_odd_odd   <= '0;
            end else begin
                input_data_even_even <= mem_ee[rd_idx];
                input_data_even_odd  <= mem_eo[rd_idx];
                input_data_odd_even  <= mem_oe[rd_idx];
                input_data_odd_odd   <= mem_oo[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_layer3_pixel_buffer.sv
// Self-checking bench for layer3_pixel_buffer against a frame-level model.
module tb_layer3_pixel_buffer;

    localparam int unsigned IN_DIM = 32;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned HALF   = IN_DIM / 2;
    localparam int          NPIX   = IN_DIM * IN_DIM;

    logic              clk = 1'b0;
    logic              rst;
    logic              save_enable;
    logic [ADDR_W-1:0] input_row;
    logic [ADDR_W-1:0] input_col;
    logic [DATA_W-1:0] input_data;
    logic              pixel_store_done;
    logic              read_pixel_signal;
    logic [ADDR_W-1:0] read_row_addr;
    logic [ADDR_W-1:0] read_col_addr;
    logic              layer3_calculation_done;
    logic [DATA_W-1:0] input_data_even_even;
    logic [DATA_W-1:0] input_data_even_odd;
    logic [DATA_W-1:0] input_data_odd_even;
    logic [DATA_W-1:0] input_data_odd_odd;
    logic              buffer_full;

    layer3_pixel_buffer #(
        .IN_DIM(IN_DIM),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .save_enable            (save_enable),
        .input_row              (input_row),
        .input_col              (input_col),
        .input_data             (input_data),
        .pixel_store_done       (pixel_store_done),
        .read_pixel_signal      (read_pixel_signal),
        .read_row_addr          (read_row_addr),
        .read_col_addr          (read_col_addr),
        .layer3_calculation_done(layer3_calculation_done),
        .input_data_even_even   (input_data_even_even),
        .input_data_even_odd    (input_data_even_odd),
        .input_data_odd_even    (input_data_odd_even),
        .input_data_odd_odd     (input_data_odd_odd),
        .buffer_full            (buffer_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: whole frame as a 2-D pixel array plus mode/count.
    bit                m_serve;
    int                m_count;
    logic              m_done;
    logic              m_full;
    logic [DATA_W-1:0] m_out [4];
    logic [DATA_W-1:0] m_mem [IN_DIM][IN_DIM];

    function automatic logic [DATA_W-1:0] pat(input int r, input int c, input bit swap);
        logic [7:0]  rb;
        logic [7:0]  cb;
        logic [15:0] lane;
        rb   = 8'(r);
        cb   = 8'(c);
        lane = swap ? {cb, rb} : {rb, cb};
        return {8{lane}};
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int ir, ic, rr, rc;
        ir = int'(input_row);
        ic = int'(input_col);
        rr = int'(read_row_addr);
        rc = int'(read_col_addr);
        if (rst) begin
            m_serve = 1'b0;
            m_count = 0;
            m_done  = 1'b0;
            m_full  = 1'b0;
            for (int i = 0; i < 4; i++) m_out[i] = '0;
        end else begin
            m_done = 1'b0;
            if (!m_serve) begin
                if (save_enable && ir < IN_DIM && ic < IN_DIM) begin
                    m_mem[ir][ic] = input_data;
                    m_count++;
                    if (m_count == NPIX) begin
                        m_count = 0;
                        m_serve = 1'b1;
                        m_done  = 1'b1;
                    end
                end
            end else begin
                if (read_pixel_signal) begin
                    if (rr < HALF && rc < HALF) begin
                        m_out[0] = m_mem[2*rr][2*rc];
                        m_out[1] = m_mem[2*rr][2*rc+1];
                        m_out[2] = m_mem[2*rr+1][2*rc];
                        m_out[3] = m_mem[2*rr+1][2*rc+1];
                    end else begin
                        for (int i = 0; i < 4; i++) m_out[i] = '0;
                    end
                end
                if (layer3_calculation_done) m_serve = 1'b0;
            end
            m_full = m_serve;
        end
    endtask

    // One clock: advance the model on the edge, then compare away from it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("pixel_store_done", DATA_W'(pixel_store_done), DATA_W'(m_done));
        chk("buffer_full", DATA_W'(buffer_full), DATA_W'(m_full));
        chk("out_ee", input_data_even_even, m_out[0]);
        chk("out_eo", input_data_even_odd, m_out[1]);
        chk("out_oe", input_data_odd_even, m_out[2]);
        chk("out_oo", input_data_odd_odd, m_out[3]);
    endtask

    task automatic idle();
        save_enable             = 1'b0;
        read_pixel_signal       = 1'b0;
        layer3_calculation_done = 1'b0;
        input_row               = '0;
        input_col               = '0;
        input_data              = '0;
        read_row_addr           = '0;
        read_col_addr           = '0;
    endtask

    // Raster writes k in [from,to) with random gaps, stray reads and out-of-range writes.
    task automatic fill(input int from, input int to, input bit swap);
        for (int k = from; k < to; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle();
                save_enable       = 1'b1;
                input_row         = ADDR_W'(IN_DIM + $urandom_range(0, 3));
                input_col         = ADDR_W'($urandom_range(0, IN_DIM - 1));
                input_data        = {4{$urandom}};
                read_pixel_signal = 1'($urandom_range(0, 1));
                read_row_addr     = ADDR_W'($urandom_range(0, HALF - 1));
                read_col_addr     = ADDR_W'($urandom_range(0, HALF - 1));
                step();
            end
            idle();
            save_enable             = 1'b1;
            input_row               = ADDR_W'(k / IN_DIM);
            input_col               = ADDR_W'(k % IN_DIM);
            input_data              = pat(k / IN_DIM, k % IN_DIM, swap);
            read_pixel_signal       = 1'($urandom_range(0, 1));
            read_row_addr           = ADDR_W'($urandom_range(0, HALF - 1));
            read_col_addr           = ADDR_W'($urandom_range(0, HALF - 1));
            layer3_calculation_done = (k == NPIX - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
        idle();
    endtask

    task automatic rd(input int r, input int c);
        idle();
        read_pixel_signal = 1'b1;
        read_row_addr     = ADDR_W'(r);
        read_col_addr     = ADDR_W'(c);
        step();
    endtask

    task automatic rand_reads(input int n, input int maxv);
        for (int i = 0; i < n; i++) begin
            idle();
            read_pixel_signal = 1'b1;
            read_row_addr     = ADDR_W'($urandom_range(0, maxv));
            read_col_addr     = ADDR_W'($urandom_range(0, maxv));
            save_enable       = 1'($urandom_range(0, 1));
            input_row         = ADDR_W'($urandom_range(0, IN_DIM - 1));
            input_col         = ADDR_W'($urandom_range(0, IN_DIM - 1));
            input_data        = {4{$urandom}};
            step();
        end
        idle();
    endtask

    initial begin
        logic [DATA_W-1:0] w;
        for (int r = 0; r < IN_DIM; r++)
            for (int c = 0; c < IN_DIM; c++) m_mem[r][c] = '0;
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Frame 1: lanes {row, col}.
        fill(0, NPIX, 1'b0);
        chk("done_after_last_write", DATA_W'(pixel_store_done), DATA_W'(1));
        chk("full_with_done", DATA_W'(buffer_full), DATA_W'(1));

        rd(3, 5);
        w = input_data_even_even; chk("rd35_ee", DATA_W'(w[15:0]), DATA_W'(16'h060A));
        w = input_data_even_odd;  chk("rd35_eo", DATA_W'(w[15:0]), DATA_W'(16'h060B));
        w = input_data_odd_even;  chk("rd35_oe", DATA_W'(w[15:0]), DATA_W'(16'h070A));
        w = input_data_odd_odd;   chk("rd35_oo", DATA_W'(w[15:0]), DATA_W'(16'h070B));

        for (int r = 0; r < HALF; r++)
            for (int c = 0; c < HALF; c++) rd(r, c);

        rd(16, 0);
        chk("oob_read_zero", input_data_odd_odd, '0);

        // Write during SERVE is ignored while the concurrent read is served.
        idle();
        save_enable       = 1'b1;
        input_data        = '1;
        read_pixel_signal = 1'b1;
        step();
        rd(0, 0);
        w = input_data_even_even; chk("serve_write_blocked", DATA_W'(w[15:0]), DATA_W'(16'h0000));

        // Outputs hold with no read strobe.
        idle();
        for (int i = 0; i < 4; i++) begin
            read_row_addr = ADDR_W'($urandom_range(0, HALF - 1));
            read_col_addr = ADDR_W'($urandom_range(0, HALF - 1));
            step();
        end

        rand_reads(60, HALF + 1);

        // Release with a read on the same edge.
        idle();
        read_pixel_signal       = 1'b1;
        read_row_addr           = ADDR_W'(1);
        read_col_addr           = ADDR_W'(1);
        layer3_calculation_done = 1'b1;
        step();
        chk("full_falls", DATA_W'(buffer_full), DATA_W'(0));
        rd(2, 2);
        idle();
        layer3_calculation_done = 1'b1;
        step();

        // Frame 2 (lanes {col, row}) interrupted by reset after 500 writes.
        fill(0, 500, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("reset_clears_out", input_data_even_even, '0);
        fill(0, 524, 1'b1);
        chk("no_done_after_524", DATA_W'(pixel_store_done), DATA_W'(0));
        fill(524, NPIX, 1'b1);
        chk("done_frame2", DATA_W'(pixel_store_done), DATA_W'(1));

        rd(3, 5);
        w = input_data_even_even; chk("f2_rd35_ee", DATA_W'(w[15:0]), DATA_W'(16'h0A06));
        w = input_data_odd_odd;   chk("f2_rd35_oo", DATA_W'(w[15:0]), DATA_W'(16'h0B07));
        rand_reads(100, HALF - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
